div_share_arbiter: RTL

//  Shares one RestoringDividerFinal-style divider core (start pulse in, valid pulse out) among N_REQ requesters.

---
 rtl/div_share_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one start/valid divider core among N_REQ clients.
// Divide-by-zero is answered locally; a core that never answers is released by a timeout.
//
// state | meaning
// IDLE  | waiting for a request; req_ready offered to the round-robin winner
// ISSUE | operands held on div_dividend/div_divisor, div_start pulsed
// WAIT  | counting cycles until div_valid or timeout
// RESP  | response held on rsp_* until rsp_ready
module div_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_dividend,
  input  logic [N_REQ*WIDTH-1:0]     req_divisor,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder,
  input  logic                       div_valid,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_div0,
  output logic                       rsp_timeout,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;
  logic             tmo_q, tmo_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   rr_next;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic             accept;

  // Winner search starts at rr_ptr and wraps, so N_REQ need not be a power of two.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == grant_idx) begin
        sel_dividend = req_dividend[k*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[k*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + IDW'(1);
  assign accept  = (state_q == S_IDLE) && grant_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div0_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div0_q     <= div0_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div0_d     = div0_q;
    tmo_d      = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rr_ptr_d   = rr_next;
          id_d       = grant_idx;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          tmo_d      = 1'b0;
          if (sel_divisor == '0) begin
            // Zero divisor never reaches the core: all-ones quotient, dividend as remainder.
            quot_d  = '1;
            rem_d   = sel_dividend;
            div0_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            div0_d  = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the expiry cycle still wins over the timeout.
        if (div_valid) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          quot_d  = '0;
          rem_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (grant_found) req_ready[grant_idx] = 1'b1;
      end
      S_ISSUE: div_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign rsp_id        = id_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_div0      = div0_q;
  assign rsp_timeout   = tmo_q;

endmodule
